// File: rtl/fpu_pkg.sv
// Shared single-precision helpers for the FPU arithmetic units and their result path.
package fpu_pkg;

    localparam int          FP_EXP_MSB = 30;
    localparam int          FP_EXP_LSB = 23;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam int          FP_MAN_W   = 23;

    typedef struct packed {
        logic                sign;
        logic [7:0]          exp;
        logic [FP_MAN_W-1:0] man;
    } fp32_t;

    function automatic fp32_t fp32_unpack(input logic [31:0] w);
        fp32_t f;
        f.sign = w[31];
        f.exp  = w[FP_EXP_MSB:FP_EXP_LSB];
        f.man  = w[FP_MAN_W-1:0];
        return f;
    endfunction

    function automatic logic fp32_is_nan(input logic [31:0] w);
        fp32_t f;
        f = fp32_unpack(w);
        return (f.exp == FP_EXP_MAX) && (f.man != {FP_MAN_W{1'b0}});
    endfunction

    function automatic logic fp32_is_inf(input logic [31:0] w);
        fp32_t f;
        f = fp32_unpack(w);
        return (f.exp == FP_EXP_MAX) && (f.man == {FP_MAN_W{1'b0}});
    endfunction

endpackage

// File: rtl/fpu_ring_buf.sv
// Ring buffer storage with read/write pointers and occupancy; no write-to-read bypass.
module fpu_ring_buf
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic          i_ld_en,
    input  logic [31:0]   i_wr_data,
    output logic [31:0]   o_rd_data,
    output logic [CW-1:0] o_level,
    output logic [CW-1:0] o_next_level
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_level;
    logic [CW-1:0] w_next_level;

    assign w_next_level = r_level + CW'(i_wr_en) - CW'(i_ld_en);
    assign o_next_level = w_next_level;
    assign o_level      = r_level;
    assign o_rd_data    = r_mem[r_rd_ptr];

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en && !rst) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_level  <= {CW{1'b0}};
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_ld_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level <= w_next_level;
        end
    end

endmodule

// File: rtl/fpu_result_fifo.sv
// STB/BUSY result receiver: ring buffer, downstream output register and sticky NaN/Inf flags.
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   in_data,
    input  logic          in_STB,
    output logic          in_BUSY,
    output logic [31:0]   out_data,
    output logic          out_STB,
    input  logic          out_BUSY,
    output logic [CW-1:0] level,
    output logic          flag_nan,
    output logic          flag_inf,
    input  logic          flag_clr
);

    logic          r_in_busy;
    logic          r_out_stb;
    logic [31:0]   r_out_data;
    logic          r_flag_nan;
    logic          r_flag_inf;
    logic          w_wr_en;
    logic          w_ld_en;
    logic [31:0]   w_rd_data;
    logic [CW-1:0] w_level;
    logic [CW-1:0] w_next_level;

    assign w_wr_en = in_STB && !r_in_busy;
    assign w_ld_en = (w_level != {CW{1'b0}}) && (!r_out_stb || !out_BUSY);

    fpu_ring_buf #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ring (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (w_wr_en),
        .i_ld_en      (w_ld_en),
        .i_wr_data    (in_data),
        .o_rd_data    (w_rd_data),
        .o_level      (w_level),
        .o_next_level (w_next_level)
    );

    // Handshake state and sticky flags; a flagging write beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_busy  <= 1'b0;
            r_out_stb  <= 1'b0;
            r_flag_nan <= 1'b0;
            r_flag_inf <= 1'b0;
        end else begin
            r_in_busy <= (w_next_level == CW'(DEPTH));
            if (w_ld_en) begin
                r_out_stb <= 1'b1;
            end else if (r_out_stb && !out_BUSY) begin
                r_out_stb <= 1'b0;
            end else begin
                r_out_stb <= r_out_stb;
            end
            r_flag_nan <= (r_flag_nan && !flag_clr) || (w_wr_en && fp32_is_nan(in_data));
            r_flag_inf <= (r_flag_inf && !flag_clr) || (w_wr_en && fp32_is_inf(in_data));
        end
    end

    // Output word holds its last value whenever no load happens.
    always_ff @(posedge clk) begin
        if (w_ld_en && !rst) begin
            r_out_data <= w_rd_data;
        end
    end

    assign in_BUSY  = r_in_busy;
    assign out_STB  = r_out_stb;
    assign out_data = r_out_data;
    assign level    = w_level;
    assign flag_nan = r_flag_nan;
    assign flag_inf = r_flag_inf;

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Scoreboard bench for fpu_result_fifo: directed pushes feed an expected queue checked by a monitor.
module tb_fpu_result_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   in_data = 32'h0;
    logic          in_STB = 1'b0;
    logic          in_BUSY;
    logic [31:0]   out_data;
    logic          out_STB;
    logic          out_BUSY = 1'b0;
    logic [CW-1:0] level;
    logic          flag_nan;
    logic          flag_inf;
    logic          flag_clr = 1'b0;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   expq [$];

    always #5 clk = ~clk;

    fpu_result_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_STB   (in_STB),
        .in_BUSY  (in_BUSY),
        .out_data (out_data),
        .out_STB  (out_STB),
        .out_BUSY (out_BUSY),
        .level    (level),
        .flag_nan (flag_nan),
        .flag_inf (flag_inf),
        .flag_clr (flag_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a take happens at the next rising edge when STB is high and BUSY low.
    always @(negedge clk) begin
        if (!rst && out_STB && !out_BUSY) begin
            n_checks++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
                logic [31:0] e;
                e = expq.pop_front();
                if (out_data !== e) begin
                    n_fail++;
                    $display("FAIL out_data_order: got %h expected %h at %0t", out_data, e, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        in_data = d;
        in_STB  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!in_BUSY) begin
                expq.push_back(d);
                ok = 1'b1;
                break;
            end
        end
        step();
        in_STB = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got busy expected accept of %h", d);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (expq.size() == 0 && !out_STB) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("drain_complete", {31'h0, ok}, 32'h1);
    endtask

    initial begin
        step();
        step();
        check("rst_in_busy", {31'h0, in_BUSY}, 32'h0);
        check("rst_out_stb", {31'h0, out_STB}, 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_flags", {30'h0, flag_nan, flag_inf}, 32'h0);
        rst = 1'b0;
        step();

        // 1: single word latency
        push(32'h3F800000);
        check("t1_stb_after_accept", {31'h0, out_STB}, 32'h0);
        check("t1_in_busy", {31'h0, in_BUSY}, 32'h0);
        check("t1_level", 32'(level), 32'h1);
        step();
        check("t1_stb_second_edge", {31'h0, out_STB}, 32'h1);
        check("t1_data", out_data, 32'h3F800000);
        step();
        check("t1_stb_after_take", {31'h0, out_STB}, 32'h0);
        drain();

        // 2: fill to DEPTH+1 under backpressure
        out_BUSY = 1'b1;
        for (int k = 1; k <= DEPTH + 1; k++) push(32'(k));
        check("t2_in_busy_full", {31'h0, in_BUSY}, 32'h1);
        check("t2_level_full", 32'(level), 32'(DEPTH));
        in_data = 32'h6;
        in_STB  = 1'b1;
        for (int k = 0; k < 3; k++) step();
        in_STB = 1'b0;
        check("t2_ignored_level", 32'(level), 32'(DEPTH));
        check("t2_ignored_busy", {31'h0, in_BUSY}, 32'h1);
        check("t2_stable_data", out_data, 32'h1);
        check("t2_stable_stb", {31'h0, out_STB}, 32'h1);
        out_BUSY = 1'b0;
        step();
        check("t2_busy_falls", {31'h0, in_BUSY}, 32'h0);
        check("t2_level_after_load", 32'(level), 32'(DEPTH - 1));
        drain();

        // 3: streaming with pointer wrap
        for (int k = 0; k < 3 * DEPTH; k++) begin
            push(32'hA000_0000 + 32'(k));
            check("t3_level_le1", {31'h0, (level <= CW'(1))}, 32'h1);
        end
        drain();

        // 4: sticky flags
        push(32'h7FC00000);
        push(32'hFF800000);
        check("t4_nan_set", {31'h0, flag_nan}, 32'h1);
        check("t4_inf_set", {31'h0, flag_inf}, 32'h1);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("t4_clr_nan", {31'h0, flag_nan}, 32'h0);
        check("t4_clr_inf", {31'h0, flag_inf}, 32'h0);
        flag_clr = 1'b1;
        push(32'h7F800000);
        flag_clr = 1'b0;
        check("t4_set_wins_inf", {31'h0, flag_inf}, 32'h1);
        check("t4_set_wins_nan", {31'h0, flag_nan}, 32'h0);
        drain();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;

        // 5: reset mid-transfer
        out_BUSY = 1'b1;
        push(32'h11111111);
        push(32'h7FC00001);
        push(32'h33333333);
        push(32'h44444444);
        check("t5_level3", 32'(level), 32'h3);
        check("t5_nan_before_rst", {31'h0, flag_nan}, 32'h1);
        in_data = 32'hDEADBEEF;
        in_STB  = 1'b1;
        rst     = 1'b1;
        step();
        rst    = 1'b0;
        in_STB = 1'b0;
        expq.delete();
        check("t5_in_busy", {31'h0, in_BUSY}, 32'h0);
        check("t5_out_stb", {31'h0, out_STB}, 32'h0);
        check("t5_level", 32'(level), 32'h0);
        check("t5_flags", {30'h0, flag_nan, flag_inf}, 32'h0);
        out_BUSY = 1'b0;
        push(32'h40000000);
        drain();

        // 6: adder results 1.0+2.0 and 1.0+(-1.0)
        push(32'h40400000);
        push(32'h00000000);
        drain();
        check("t6_level_empty", 32'(level), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_result_fifo.md
Name: fpu_result_fifo

Overview:
- Receiving end of the STB/BUSY result interface of the FPU arithmetic units (adder, and later mul/div).
- Sits in the output-module position: presents BUSY back to the FPU and accepts single-precision results into a DEPTH-entry ring buffer.
- Re-issues results downstream over an identical STB/BUSY interface.
- Keeps an occupancy count and sticky IEEE exception flags (NaN, Inf) for software/status.

Parameters:
DEPTH, 4, ring-buffer entries (power of 2, >=2); the output register is additional, so total capacity is DEPTH+1.
CW, $clog2(DEPTH+1), width of the level output.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high; single clock domain
in_data  input  32  result word from FPU unit
in_STB  input  1  FPU result valid
in_BUSY  output  1  to FPU output_module_BUSY; high = cannot accept
out_data  output  32  result word to consumer
out_STB  output  1  out_data valid
out_BUSY  input  1  consumer busy
level  output  CW  ring entries occupied (excludes output register)
flag_nan  output  1  sticky: a NaN result was accepted
flag_inf  output  1  sticky: an infinity result was accepted
flag_clr  input  1  clear both sticky flags

Behaviour:
- Protocol, both sides: a transaction occurs at a rising edge where STB=1 and BUSY=0. The sender holds its data until the clock after the transaction. out_data holds its last valid value while out_STB=0.
- Reset values (rst=1 at an edge):
  - in_BUSY=0, out_STB=0, level=0, flag_nan=0, flag_inf=0.
  - Read and write pointers = 0.
  - out_data and ring contents are don't-care; the bench must not check them.
  - rst dominates all other activity in the same cycle, including mid-transfer. Buffered words are discarded.
- Write (accept):
  - wr_en = in_STB && !in_BUSY.
  - mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Load (ring -> output register):
  - ld_en = (level != 0) && (!out_STB || !out_BUSY).
  - out_data <= mem[rd_ptr]; out_STB <= 1; rd_ptr increments modulo DEPTH.
- Drain: if out_STB && !out_BUSY && !ld_en, then out_STB <= 0 and out_data holds.
- Level update:
  - level <= level + wr_en - ld_en.
  - Simultaneous write and load leaves level unchanged.
  - A word written in cycle N is not loadable before cycle N+1 (no bypass).
- Backpressure:
  - in_BUSY is registered: in_BUSY <= (next_level == DEPTH).
  - It is therefore high at the edge after the DEPTH-th entry is taken, so overflow is impossible.
  - It deasserts in the cycle after a load frees an entry. It is never lowered unless an entry is free.
- Latency:
  - An accepted word reaches out_STB=1 two edges after acceptance when the block is empty and the consumer is idle.
  - Sustained throughput is 1 word/cycle with out_BUSY=0.
- Ordering: strict FIFO. No data is dropped or duplicated. With out_BUSY held high, out_data/out_STB stay stable.
- Flags, evaluated on accepted words only:
  - NaN: exponent == 8'hFF and mantissa != 0.
  - Inf: exponent == 8'hFF and mantissa == 0.
  - The flags are sticky until flag_clr.
  - If flag_clr and a flagging write occur in the same cycle, set wins.
- Boundary conditions:
  - Full (level=DEPTH) with a load in the same cycle: level becomes DEPTH-1, and in_BUSY falls on the next edge.
  - Empty with out_STB=1 and a consumer take: out_STB falls.
  - in_STB while in_BUSY=1: ignored; no state change.

Decomposition:
- Package fpu_pkg:
  - Constants: FP_EXP_MSB=30, FP_EXP_LSB=23, FP_EXP_MAX=8'hFF, FP_MAN_W=23.
  - Function/typedef for fp32 field extraction (sign, exp, man), shared with the adder.
- Natural sub-module: fpu_ring_buf.
  - Holds memory, pointers and level, with wr_en/ld_en inputs.
  - The top level holds the handshake, output register and flags.

Test Plan:
1. Reset with out_BUSY=0; push 0x3F800000 (1.0) one cycle later -> in_BUSY stays 0; out_STB=1 with out_data=0x3F800000 exactly two edges after acceptance; out_STB=0 on the edge after the take.
2. out_BUSY=1, push DEPTH+1 words 0x00000001..0x00000005 -> all 5 accepted (4 ring + 1 output register); in_BUSY=1 afterwards; level=4; a 6th in_STB is ignored. Release out_BUSY -> 1,2,3,4,5 emerge in order and in_BUSY falls after the first load.
3. Continuous push and out_BUSY=0 for 3*DEPTH words -> one output per cycle after fill; pointer wrap occurs without loss or reorder; level never exceeds 1.
4. Push 0x7FC00000 then 0xFF800000 -> flag_nan=1, flag_inf=1. Assert flag_clr alone -> both 0. Assert flag_clr in the same cycle as accepting 0x7F800000 -> flag_inf=1.
5. Fill to level=3, assert rst for one cycle mid-transfer -> next edge in_BUSY=0, out_STB=0, level=0, flags 0; subsequent push 0x40000000 emerges first.
6. Connect to the adder (in = adder output pair): feed 1.0+2.0 and 1.0+(-1.0) -> the consumer receives 0x40400000 then 0x00000000 in order.
